// File: rtl/seq_fsm_pkg.sv
// Shared types and symbol constants for the seq_fsm sequence recogniser.
package seq_fsm_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GOT1 = 2'd1,
    GOT2 = 2'd2,
    OUT  = 2'd3
  } state_t;

  localparam logic [1:0] SYM_START = 2'b10;
  localparam logic [1:0] SYM_MID   = 2'b01;
  localparam logic [1:0] SYM_END   = 2'b11;

endpackage

// File: rtl/seq_fsm_hold_cnt.sv
// Loadable down-counter with a zero flag, used to time the detection pulse.
module seq_fsm_hold_cnt
  import seq_fsm_pkg::*;
#(
  parameter int CNT_W = 2
) (
  input  logic             ck,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // A load wins over a decrement; the count saturates at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge ck) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/seq_fsm.sv
// Moore recogniser for {a,b} = 10 -> 01 -> 11; holds s high for HOLD_CYCLES cycles.
// Define SEQ_FSM_DBG_EN to expose the state register on dbg_state.
module seq_fsm
  import seq_fsm_pkg::*;
#(
  parameter int HOLD_CYCLES = 2
) (
  input  logic       ck,
  input  logic       rst_n,
  input  logic       a,
  input  logic       b,
  output logic       s
`ifdef SEQ_FSM_DBG_EN
  ,
  output logic [1:0] dbg_state
`endif
);

  localparam int CNT_W = $clog2(HOLD_CYCLES + 1);
  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(HOLD_CYCLES - 1);

  state_t     state_q;
  state_t     state_d;
  logic [1:0] sym;
  logic       cnt_load;
  logic       cnt_dec;
  logic       cnt_zero;

  assign sym = {a, b};

  always_ff @(posedge ck) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // A fresh start symbol from any matching state re-arms at GOT1.
  always_comb begin
    state_d  = state_q;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    case (state_q)
      IDLE: begin
        if (sym == SYM_START) state_d = GOT1;
      end
      GOT1: begin
        if (sym == SYM_MID)        state_d = GOT2;
        else if (sym == SYM_START) state_d = GOT1;
        else                       state_d = IDLE;
      end
      GOT2: begin
        if (sym == SYM_END) begin
          state_d  = OUT;
          cnt_load = 1'b1;
        end else if (sym == SYM_START) begin
          state_d = GOT1;
        end else begin
          state_d = IDLE;
        end
      end
      OUT: begin
        if (cnt_zero) state_d = IDLE;
        else          cnt_dec = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  seq_fsm_hold_cnt #(
    .CNT_W(CNT_W)
  ) u_hold_cnt (
    .ck      (ck),
    .rst_n   (rst_n),
    .load    (cnt_load),
    .load_val(LOAD_VAL),
    .dec     (cnt_dec),
    .zero    (cnt_zero)
  );

  assign s = (state_q == OUT);

`ifdef SEQ_FSM_DBG_EN
  assign dbg_state = state_q;
`endif

endmodule

// File: tb/tb_seq_fsm.sv
// Self-checking bench for seq_fsm: four hold lengths share one stimulus stream.
module tb_seq_fsm;

  logic       ck = 1'b0;
  logic       rst_n = 1'b0;
  logic       a = 1'b0;
  logic       b = 1'b0;
  logic [3:0] s_vec;
  logic [1:0] dbg_vec [4];

  int total = 0;
  int bad = 0;

  // Reference model: outstanding pulse cycles plus the symbols seen since the
  // machine last became able to match (reset or end of a pulse).
  int         hold_left [4];
  logic [5:0] win [4];
  int         wlen [4];

  always #5 ck = ~ck;

  seq_fsm #(.HOLD_CYCLES(2)) u_h2 (
    .ck(ck), .rst_n(rst_n), .a(a), .b(b), .s(s_vec[0])
`ifdef SEQ_FSM_DBG_EN
    , .dbg_state(dbg_vec[0])
`endif
  );
  seq_fsm #(.HOLD_CYCLES(3)) u_h3 (
    .ck(ck), .rst_n(rst_n), .a(a), .b(b), .s(s_vec[1])
`ifdef SEQ_FSM_DBG_EN
    , .dbg_state(dbg_vec[1])
`endif
  );
  seq_fsm #(.HOLD_CYCLES(1)) u_h1 (
    .ck(ck), .rst_n(rst_n), .a(a), .b(b), .s(s_vec[2])
`ifdef SEQ_FSM_DBG_EN
    , .dbg_state(dbg_vec[2])
`endif
  );
  seq_fsm #(.HOLD_CYCLES(255)) u_h255 (
    .ck(ck), .rst_n(rst_n), .a(a), .b(b), .s(s_vec[3])
`ifdef SEQ_FSM_DBG_EN
    , .dbg_state(dbg_vec[3])
`endif
  );

  function automatic int hold_of(input int i);
    case (i)
      0: return 2;
      1: return 3;
      2: return 1;
      default: return 255;
    endcase
  endfunction

  function automatic logic model_s(input int i);
    return (hold_left[i] > 0);
  endfunction

  // Drive one symbol across one rising edge and advance the model; outputs are
  // stable and safe to sample when this returns (#1 after the edge).
  task automatic drive_edge(input logic [1:0] x, input logic rn);
    a = x[1];
    b = x[0];
    rst_n = rn;
    @(posedge ck);
    for (int i = 0; i < 4; i++) begin
      if (!rn) begin
        hold_left[i] = 0;
        wlen[i] = 0;
        win[i] = '0;
      end else if (hold_left[i] > 0) begin
        hold_left[i] = hold_left[i] - 1;
        wlen[i] = 0;
        win[i] = '0;
      end else begin
        win[i] = {win[i][3:0], x};
        wlen[i] = wlen[i] + 1;
        if (wlen[i] >= 3 && win[i] == 6'b10_01_11) hold_left[i] = hold_of(i);
      end
    end
    #1;
  endtask

  task automatic test_reset();
    for (int e = 0; e < 2; e++) begin
      drive_edge(2'b11, 1'b0);
      total++;
      if (s_vec !== 4'b0000) begin
        bad++;
        $display("[TB] FAIL reset_s edge=%0d got=%b want=0000", e, s_vec);
      end
`ifdef SEQ_FSM_DBG_EN
      for (int i = 0; i < 4; i++) begin
        total++;
        if (dbg_vec[i] !== 2'd0) begin
          bad++;
          $display("[TB] FAIL reset_dbg inst=%0d got=%0d want=0", i, dbg_vec[i]);
        end
      end
`endif
    end
  endtask

  // Runs a symbol list after a clearing reset, checking every instance against
  // the model and one chosen instance against a hand-written pulse pattern.
  task automatic run_pattern(input string name, input logic [1:0] syms [],
                             input int inst, input logic exp_pat []);
    drive_edge(2'b00, 1'b0);
    for (int e = 0; e < syms.size(); e++) begin
      drive_edge(syms[e], 1'b1);
      total++;
      if (s_vec[inst] !== exp_pat[e]) begin
        bad++;
        $display("[TB] FAIL %s edge=%0d got=%b want=%b", name, e + 1, s_vec[inst], exp_pat[e]);
      end
      for (int i = 0; i < 4; i++) begin
        total++;
        if (s_vec[i] !== model_s(i)) begin
          bad++;
          $display("[TB] FAIL %s_model inst=%0d edge=%0d got=%b want=%b",
                   name, i, e + 1, s_vec[i], model_s(i));
        end
      end
    end
  endtask

  task automatic test_basic_detect();
    run_pattern("basic_h2", '{2'b10, 2'b01, 2'b11, 2'b00, 2'b00, 2'b00}, 0,
                '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0});
  endtask

  task automatic test_restart();
    run_pattern("restart_a", '{2'b10, 2'b10, 2'b01, 2'b11, 2'b00}, 0,
                '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1});
    run_pattern("restart_b", '{2'b10, 2'b01, 2'b10, 2'b01, 2'b11, 2'b00}, 0,
                '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1});
  endtask

  task automatic test_broken();
    run_pattern("broken_a", '{2'b10, 2'b00, 2'b01, 2'b11, 2'b00}, 0,
                '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
    run_pattern("broken_b", '{2'b01, 2'b11, 2'b00}, 0,
                '{1'b0, 1'b0, 1'b0});
  endtask

  task automatic test_ignore_in_out();
    run_pattern("ignore_h3", '{2'b10, 2'b01, 2'b11, 2'b10, 2'b01, 2'b11, 2'b00, 2'b00}, 1,
                '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0});
  endtask

  task automatic test_back_to_back();
    run_pattern("b2b_h1", '{2'b10, 2'b01, 2'b11, 2'b00, 2'b10, 2'b01, 2'b11, 2'b00}, 2,
                '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0});
  endtask

  task automatic test_long_hold();
    int highs = 0;
    drive_edge(2'b00, 1'b0);
    drive_edge(2'b10, 1'b1);
    drive_edge(2'b01, 1'b1);
    for (int e = 0; e < 300; e++) begin
      drive_edge((e == 0) ? 2'b11 : 2'(($urandom_range(0, 3))), 1'b1);
      if (s_vec[3] === 1'b1 && e < 256) highs++;
      for (int i = 0; i < 4; i++) begin
        total++;
        if (s_vec[i] !== model_s(i)) begin
          bad++;
          $display("[TB] FAIL long_model inst=%0d edge=%0d got=%b want=%b",
                   i, e, s_vec[i], model_s(i));
        end
      end
    end
    total++;
    if (highs != 255) begin
      bad++;
      $display("[TB] FAIL long_h255_count got=%0d want=255", highs);
    end
  endtask

  task automatic test_reset_mid_out();
    drive_edge(2'b00, 1'b0);
    drive_edge(2'b10, 1'b1);
    drive_edge(2'b01, 1'b1);
    drive_edge(2'b11, 1'b1);
    total++;
    if (s_vec !== 4'b1111) begin
      bad++;
      $display("[TB] FAIL mid_out_pre got=%b want=1111", s_vec);
    end
    drive_edge(2'b11, 1'b0);
    total++;
    if (s_vec !== 4'b0000) begin
      bad++;
      $display("[TB] FAIL mid_out_reset got=%b want=0000", s_vec);
    end
  endtask

  task automatic test_random();
    logic [1:0] x;
    logic       rn;
    int         inject = 0;
    drive_edge(2'b00, 1'b0);
    for (int e = 0; e < 2000; e++) begin
      if (inject == 0 && $urandom_range(0, 5) == 0) inject = 3;
      case (inject)
        3: x = 2'b10;
        2: x = 2'b01;
        1: x = 2'b11;
        default: x = 2'($urandom_range(0, 3));
      endcase
      if (inject > 0) inject--;
      rn = ($urandom_range(0, 149) != 0);
      drive_edge(x, rn);
      for (int i = 0; i < 4; i++) begin
        total++;
        if (s_vec[i] !== model_s(i)) begin
          bad++;
          $display("[TB] FAIL random inst=%0d edge=%0d got=%b want=%b",
                   i, e, s_vec[i], model_s(i));
        end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      hold_left[i] = 0;
      win[i] = '0;
      wlen[i] = 0;
    end
    test_reset();
    test_basic_detect();
    test_restart();
    test_broken();
    test_ignore_in_out();
    test_back_to_back();
    test_long_hold();
    test_reset_mid_out();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
